// File: rtl/conv_pkg.sv
// Shared encodings for the convolution layer scheduler and its pixel counter.
package conv_pkg;

  localparam int STATE_W = 3;
  localparam int SCALE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } conv_state_e;

  localparam logic MODE_DW = 1'b0;
  localparam logic MODE_PW = 1'b1;

endpackage

// File: rtl/conv_pix_counter.sv
// Column/row position of the pixel stream; flags the final pixel of a W x H frame.
module conv_pix_counter #(
  parameter int ROW_BUFFER_DEPTH = 9
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_clr,
  input  logic                        i_en,
  input  logic [ROW_BUFFER_DEPTH-1:0] i_img_w,
  input  logic [ROW_BUFFER_DEPTH-1:0] i_img_h,
  output logic                        o_last
);

  logic [ROW_BUFFER_DEPTH-1:0] r_col;
  logic [ROW_BUFFER_DEPTH-1:0] r_row;
  logic                        w_col_wrap;
  logic                        w_row_last;

  assign w_col_wrap = (r_col == i_img_w - ROW_BUFFER_DEPTH'(1));
  assign w_row_last = (r_row == i_img_h - ROW_BUFFER_DEPTH'(1));
  assign o_last     = w_col_wrap & w_row_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= r_row + ROW_BUFFER_DEPTH'(1);
      end else begin
        r_col <= r_col + ROW_BUFFER_DEPTH'(1);
      end
    end
  end

endmodule

// File: rtl/conv_layer_scheduler.sv
// Sequences one conv layer through the shared datapath: per output group it
// loads weights, then bias, streams W*H pixels and waits for the pipeline to drain.
//
// state  | meaning
// IDLE   | waiting for start; config is checked when start arrives
// LOAD_W | weight fetch outstanding
// LOAD_B | bias fetch outstanding
// RUN    | streaming the W*H pixels of the current group
// DRAIN  | letting the multiplier/adder pipeline empty
// DONE   | one-cycle completion pulse
module conv_layer_scheduler
  import conv_pkg::*;
#(
  parameter int ROW_BUFFER_DEPTH    = 9,
  parameter int GROUP_WIDTH         = 6,
  parameter int MULT_PIPELINE_STAGE = 2,
  parameter int ADDER_LATENCY       = 4,
  parameter int DRAIN_CYCLES        = MULT_PIPELINE_STAGE + ADDER_LATENCY + 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        cfg_mode,
  input  logic [ROW_BUFFER_DEPTH-1:0] cfg_img_w,
  input  logic [ROW_BUFFER_DEPTH-1:0] cfg_img_h,
  input  logic [GROUP_WIDTH-1:0]      cfg_groups,
  input  logic [SCALE_W-1:0]          cfg_scale,
  output logic                        weight_req,
  input  logic                        weight_ack,
  output logic                        bias_req,
  input  logic                        bias_ack,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  output logic                        pix_fire,
  output logic [GROUP_WIDTH-1:0]      group_idx,
  output logic                        adder_rst,
  output logic [SCALE_W-1:0]          scale_out,
  output logic                        mode_out,
  output logic [ROW_BUFFER_DEPTH-1:0] buff_len_ctrl,
  output logic                        buff_len_rst,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  conv_state_e                 r_state;
  conv_state_e                 w_next;
  logic                        r_mode;
  logic [SCALE_W-1:0]          r_scale;
  logic [ROW_BUFFER_DEPTH-1:0] r_img_w;
  logic [ROW_BUFFER_DEPTH-1:0] r_img_h;
  logic [GROUP_WIDTH-1:0]      r_groups;
  logic [GROUP_WIDTH-1:0]      r_group_idx;
  logic [ROW_BUFFER_DEPTH-1:0] r_buff_len_ctrl;
  logic                        r_buff_len_rst;
  logic                        r_adder_rst;
  logic                        r_cfg_err;
  logic [DRAIN_W-1:0]          r_drain_cnt;

  logic w_start;
  logic w_abort;
  logic w_cfg_legal;
  logic w_last;
  logic w_more_groups;
  logic w_drain_end;
  logic w_cnt_clr;

  assign w_start = (r_state == ST_IDLE) && start;
  assign w_abort = abort && (r_state != ST_IDLE);

  // A 3x3 window needs at least three columns and three rows to exist.
  assign w_cfg_legal = (cfg_groups != '0) && (cfg_img_w != '0) && (cfg_img_h != '0) &&
                       !((cfg_mode == MODE_DW) &&
                         ((cfg_img_w < ROW_BUFFER_DEPTH'(3)) || (cfg_img_h < ROW_BUFFER_DEPTH'(3))));

  assign w_more_groups = (r_group_idx < (r_groups - GROUP_WIDTH'(1)));
  assign w_drain_end   = (r_state == ST_DRAIN) && (r_drain_cnt == '0);
  assign w_cnt_clr     = (r_state != ST_RUN) || w_abort;
  assign pix_fire      = pix_valid & pix_ready;

  conv_pix_counter #(
    .ROW_BUFFER_DEPTH(ROW_BUFFER_DEPTH)
  ) u_pix_counter (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (w_cnt_clr),
    .i_en   (pix_fire),
    .i_img_w(r_img_w),
    .i_img_h(r_img_h),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start && w_cfg_legal) w_next = ST_LOAD_W;
      ST_LOAD_W: if (weight_ack) w_next = ST_LOAD_B;
      ST_LOAD_B: if (bias_ack) w_next = ST_RUN;
      ST_RUN:    if (pix_fire && w_last) w_next = ST_DRAIN;
      ST_DRAIN:  if (w_drain_end) w_next = w_more_groups ? ST_LOAD_W : ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  // Abort wins over a same-cycle pixel, so ready is withdrawn while it is high.
  always_comb begin
    weight_req = 1'b0;
    bias_req   = 1'b0;
    pix_ready  = 1'b0;
    done       = 1'b0;
    busy       = (r_state != ST_IDLE);
    case (r_state)
      ST_LOAD_W: weight_req = 1'b1;
      ST_LOAD_B: bias_req   = 1'b1;
      ST_RUN:    pix_ready  = ~abort;
      ST_DONE:   done       = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mode          <= 1'b0;
      r_scale         <= '0;
      r_img_w         <= '0;
      r_img_h         <= '0;
      r_groups        <= '0;
      r_cfg_err       <= 1'b0;
      r_buff_len_ctrl <= '0;
      r_buff_len_rst  <= 1'b0;
    end else begin
      r_buff_len_rst <= 1'b0;
      if (w_start) begin
        r_mode    <= cfg_mode;
        r_scale   <= cfg_scale;
        r_img_w   <= cfg_img_w;
        r_img_h   <= cfg_img_h;
        r_groups  <= cfg_groups;
        r_cfg_err <= ~w_cfg_legal;
        if (w_cfg_legal) begin
          r_buff_len_rst  <= 1'b1;
          r_buff_len_ctrl <= (cfg_mode == MODE_DW) ? (cfg_img_w - ROW_BUFFER_DEPTH'(2)) : '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_group_idx <= '0;
      r_drain_cnt <= '0;
      r_adder_rst <= 1'b0;
    end else begin
      r_adder_rst <= (r_state == ST_LOAD_B) && (w_next == ST_RUN);
      if (w_abort) begin
        r_group_idx <= '0;
        r_drain_cnt <= '0;
      end else if (w_start && w_cfg_legal) begin
        r_group_idx <= '0;
      end else if ((r_state == ST_RUN) && (w_next == ST_DRAIN)) begin
        r_drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
      end else if (r_state == ST_DRAIN) begin
        if (r_drain_cnt != '0) r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
        if (w_next == ST_LOAD_W) r_group_idx <= r_group_idx + GROUP_WIDTH'(1);
      end
    end
  end

  assign group_idx     = r_group_idx;
  assign adder_rst     = r_adder_rst;
  assign scale_out     = r_scale;
  assign mode_out      = r_mode;
  assign buff_len_ctrl = r_buff_len_ctrl;
  assign buff_len_rst  = r_buff_len_rst;
  assign cfg_err       = r_cfg_err;

endmodule
